seg7_display_driver: RTL and testbench
======================================

Name: seg7_display_driver

Overview:
- Downstream consumer of the CPU top's 32-bit result bus (`out`, the ALU result); shows it on the board's 8-digit multiplexed 7-segment display.
- Latches a value on a load strobe and shows it in hex or in unsigned decimal.
- Decimal uses a sequential double-dabble binary-to-BCD converter.
- Time-multiplexes the digits with a programmable refresh divider.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit; minimum 2.
- DIGITS, 8, number of display digits; fixed at 8 in this revision.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- value  in  32  data to display; sampled only on an accepted load.
- mode  in  1  0 = hex, 1 = unsigned decimal; sampled with value on an accepted load.
- load  in  1  single-cycle strobe; accepted only when busy=0.
- busy  out  1  high while a decimal conversion is running.
- seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
- an_n  out  8  active-low digit enables; an_n[0] is the rightmost digit.

Behaviour:
- Reset (async, rst=1):
  - busy=0, seg_n=8'hFF, an_n=8'hFF (display dark).
  - Display buffer cleared to eight hex zeros.
  - Digit index=0, refresh counter=0, FSM=IDLE.
- After reset release: display shows "00000000".
- FSM states: IDLE, CONV, COMMIT.
- IDLE, load=1, mode=0 (hex): the next clk edge writes nibble k of value into buffer digit k. Latency is 1 cycle. busy stays 0.
- IDLE, load=1, mode=1 (decimal): value latched into the shift register, BCD register cleared, iteration count=0, go to CONV, busy=1 from the next edge.
- CONV: one double-dabble iteration per clk.
  - Add 3 to every BCD nibble that is >=5.
  - Then shift {bcd, bin} left by 1.
  - After exactly 32 iterations go to COMMIT.
  - BCD register is 40 bits (10 digits).
- COMMIT (one cycle):
  - If BCD digits 9..8 are nonzero (value > 99_999_999), all 8 buffer digits become DASH.
  - Otherwise the buffer takes the low 8 BCD digits.
  - Return to IDLE; busy=0 after this edge.
- Total decimal latency: load edge to buffer update = 34 clk; busy high for 33 cycles.
- load while busy=1 is ignored; no queueing. The conversion in flight completes unaffected.
- The buffer updates atomically: the display never shows a partially converted value; the old value is shown during CONV.
- Scan:
  - Refresh counter counts 0..REFRESH_DIV-1 then wraps.
  - On wrap, digit index increments and wraps 7->0.
- Outputs are registered, one cycle behind the index:
  - an_n = ~(1 << index).
  - seg_n = {1'b1, glyph(buffer[index])}; dp is always off.
- Glyph codes ({g..a}, active low):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - A=08, b=03, C=46, d=21, E=06, F=0E.
  - DASH=3F, BLANK=7F.
- Reset mid-conversion: the conversion is aborted, the buffer returns to zeros, FSM=IDLE.

Optional Feature:
- Macro: SEG7_LZB_EN (leading-zero blanking).
- Defined: on every buffer write (hex or decimal commit), zero digits above the most significant nonzero digit become BLANK. Digit 0 always shows, so a value of 0 shows a single "0". DASH overflow is unaffected.
- Undefined: all 8 digits are always shown, including leading zeros.

Test Plan:
- Reset, REFRESH_DIV=4 -> during rst seg_n=FF, an_n=FF; after release an_n walks FE,FD,FB,...,7F,FE at 4-clk steps; seg_n=C0 on every digit.
- Hex load value=32'h1234ABCD, mode=0 -> next cycle buffer updated; digit 0 seg_n=A1 (d), digit 7 seg_n=F9 (1); busy never rises.
- Decimal load value=12345678, mode=1 -> busy high 33 cycles; digits 7..0 show 1..8 (digit 7 seg_n=F9, digit 0 seg_n=80); old value shown until commit.
- Decimal load value=32'hFFFFFFFF -> after 34 cycles all digits seg_n=BF (DASH).
- load pulsed again mid-conversion with value=5 -> ignored; first value displayed; then a load after busy falls is accepted.
- rst asserted at iteration 10 of CONV -> busy=0 immediately; display "00000000". With SEG7_LZB_EN, decimal 42 -> digits 7..2 seg_n=FF, digit 1=99, digit 0=A4.

Source files
------------

// File: rtl/seg7_display_driver_if.sv
// Load/busy handshake between the 32-bit result producer and the 7-segment display driver.
interface seg7_display_driver_if;
  logic [31:0] value;
  logic        mode;
  logic        load;
  logic        busy;

  modport master (output value, output mode, output load, input busy);
  modport slave  (input value, input mode, input load, output busy);
endinterface

// File: rtl/seg7_display_driver.sv
// 8-digit multiplexed 7-segment driver: hex or unsigned-decimal (sequential double dabble) display of a latched word.
// Optional leading-zero blanking is compiled in when SEG7_LZB_EN is defined.
module seg7_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned DIGITS      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  seg7_display_driver_if.slave   bus,
  output logic [7:0]             seg_n,
  output logic [7:0]             an_n
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(DIGITS);

  // Buffer digit codes: 0..15 hex value, plus two non-numeric glyphs
  localparam logic [4:0] D_DASH  = 5'd16;
  localparam logic [4:0] D_BLANK = 5'd17;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t                  state_q, state_nxt;
  logic [31:0]             bin_q, bin_nxt;
  logic [9:0][3:0]         bcd_q, bcd_nxt, bcd_adj;
  logic [4:0]              iter_q, iter_nxt;
  logic [DIGITS-1:0][4:0]  disp_q, disp_nxt, hex_d, dec_d;
  logic                    busy_nxt;
  logic [CW-1:0]           cnt_q;
  logic [IW-1:0]           idx_q;

  function automatic logic [6:0] glyph(input logic [4:0] code);
    case (code)
      5'd0:    glyph = 7'h40;
      5'd1:    glyph = 7'h79;
      5'd2:    glyph = 7'h24;
      5'd3:    glyph = 7'h30;
      5'd4:    glyph = 7'h19;
      5'd5:    glyph = 7'h12;
      5'd6:    glyph = 7'h02;
      5'd7:    glyph = 7'h78;
      5'd8:    glyph = 7'h00;
      5'd9:    glyph = 7'h10;
      5'd10:   glyph = 7'h08;
      5'd11:   glyph = 7'h03;
      5'd12:   glyph = 7'h46;
      5'd13:   glyph = 7'h21;
      5'd14:   glyph = 7'h06;
      5'd15:   glyph = 7'h0E;
      D_DASH:  glyph = 7'h3F;
      default: glyph = 7'h7F;
    endcase
  endfunction

  function automatic logic [DIGITS-1:0][4:0] blank_lz(input logic [DIGITS-1:0][4:0] d);
`ifdef SEG7_LZB_EN
    logic seen;
    seen     = 1'b0;
    blank_lz = d;
    // Walk from the top digit down; digit 0 is never blanked
    for (int unsigned i = 0; i < DIGITS - 1; i++) begin
      if (d[IW'(DIGITS - 1 - i)] != 5'd0) seen = 1'b1;
      if (!seen) blank_lz[IW'(DIGITS - 1 - i)] = D_BLANK;
    end
`else
    blank_lz = d;
`endif
  endfunction

  always_comb begin
    state_nxt = state_q;
    bin_nxt   = bin_q;
    bcd_nxt   = bcd_q;
    bcd_adj   = bcd_q;
    iter_nxt  = iter_q;
    disp_nxt  = disp_q;
    hex_d     = '0;
    dec_d     = '0;
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.mode) begin
            state_nxt = CONV;
            bin_nxt   = bus.value;
            bcd_nxt   = '0;
            iter_nxt  = '0;
          end else begin
            for (int unsigned k = 0; k < DIGITS; k++)
              hex_d[IW'(k)] = {1'b0, 4'(bus.value >> (4 * k))};
            disp_nxt = blank_lz(hex_d);
          end
        end
      end
      CONV: begin
        for (int unsigned k = 0; k < 10; k++)
          bcd_adj[4'(k)] = (bcd_q[4'(k)] >= 4'd5) ? bcd_q[4'(k)] + 4'd3 : bcd_q[4'(k)];
        {bcd_nxt, bin_nxt} = {bcd_adj, bin_q} << 1;
        iter_nxt = iter_q + 5'd1;
        if (iter_q == 5'd31) state_nxt = COMMIT;
      end
      COMMIT: begin
        // The display buffer only changes here, so a partial conversion is never visible
        if (bcd_q[9] != 4'd0 || bcd_q[8] != 4'd0) begin
          disp_nxt = {DIGITS{D_DASH}};
        end else begin
          for (int unsigned k = 0; k < DIGITS; k++)
            dec_d[IW'(k)] = {1'b0, bcd_q[4'(k)]};
          disp_nxt = blank_lz(dec_d);
        end
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bin_q    <= '0;
      bcd_q    <= '0;
      iter_q   <= '0;
      disp_q   <= '0;
      bus.busy <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      bin_q    <= bin_nxt;
      bcd_q    <= bcd_nxt;
      iter_q   <= iter_nxt;
      disp_q   <= disp_nxt;
      bus.busy <= busy_nxt;
    end
  end

  // Scan: digit select and segment outputs are registered one cycle behind the index
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      idx_q <= '0;
      an_n  <= '1;
      seg_n <= '1;
    end else begin
      if (cnt_q == CW'(REFRESH_DIV - 1)) begin
        cnt_q <= '0;
        idx_q <= idx_q + IW'(1);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
      an_n  <= ~(8'd1 << idx_q);
      seg_n <= {1'b1, glyph(disp_q[idx_q])};
    end
  end

endmodule

// File: tb/tb_seg7_display_driver.sv
// Randomized bench for seg7_display_driver against an arithmetic model of the displayed digits.
module tb_seg7_display_driver;

  localparam int unsigned RDIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] seg_n;
  logic [7:0] an_n;

  seg7_display_driver_if bus();

  seg7_display_driver #(.REFRESH_DIV(RDIV), .DIGITS(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .seg_n (seg_n),
    .an_n  (an_n)
  );

  always #5 clk = ~clk;

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          mdig [8];
  int unsigned ncyc;

  // Index 0..15 hex glyphs, 16 dash, 17 blank
  logic [6:0] gly [18] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00,
                           7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E, 7'h3F, 7'h7F};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_zero();
    for (int k = 0; k < 8; k++) mdig[k] = 0;
  endtask

  task automatic model_load(input logic [31:0] v, input bit dec);
    longint unsigned x     = 64'(v);
    longint unsigned radix = dec ? 10 : 16;
    longint unsigned pw    = 1;
    for (int k = 0; k < 8; k++) begin
      if (dec && x > 99999999) mdig[k] = 16;
      else begin
        mdig[k] = int'((x / pw) % radix);
`ifdef SEG7_LZB_EN
        if (k > 0 && x / pw == 0) mdig[k] = 17;
`endif
      end
      pw = pw * radix;
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  always @(negedge clk) begin
    int unsigned d;
    logic [7:0]  ea;
    if (rst || ncyc == 0) begin
      check("an_dark", 32'(an_n), 32'hFF);
      check("seg_dark", 32'(seg_n), 32'hFF);
    end else begin
      d  = ((ncyc - 1) / RDIV) % 8;
      ea = ~(8'd1 << d);
      check("an_scan", 32'(an_n), 32'(ea));
      check("seg_digit", 32'(seg_n), 32'({1'b1, gly[mdig[d]]}));
    end
  end

  // One load; inj (1..30) pulses an extra load mid-conversion that must be ignored
  task automatic send(input logic [31:0] v, input bit dec, input int inj);
    @(negedge clk);
    bus.value = v;
    bus.mode  = dec;
    bus.load  = 1'b1;
    @(posedge clk);
    #1;
    bus.load  = 1'b0;
    bus.value = $urandom;
    bus.mode  = 1'($urandom);
    check("busy_after_load", 32'(bus.busy), 32'(dec));
    if (!dec) begin
      @(posedge clk);
      #1;
      model_load(v, 1'b0);
      check("busy_hex", 32'(bus.busy), 32'd0);
    end else begin
      for (int k = 1; k <= 34; k++) begin
        @(posedge clk);
        #1;
        if (k == 34) model_load(v, 1'b1);
        check("busy_dec", 32'(bus.busy), 32'(k <= 32));
        if (k == inj) begin
          bus.value = 32'd5;
          bus.mode  = 1'($urandom);
          bus.load  = 1'b1;
        end
        if (k == inj + 1) bus.load = 1'b0;
      end
    end
    repeat (34) @(posedge clk);
  endtask

  initial begin
    logic [31:0] v;
    bit          dec;
    int          inj;
    bus.value = '0;
    bus.mode  = 1'b0;
    bus.load  = 1'b0;
    model_zero();
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (34) @(posedge clk);

    send(32'h1234ABCD, 1'b0, -1);
    send(32'd12345678, 1'b1, -1);
    send(32'hFFFFFFFF, 1'b1, -1);
    send(32'd87654321, 1'b1, 7);
    send(32'd5, 1'b0, -1);
    send(32'd42, 1'b1, -1);
    send(32'd0, 1'b1, -1);
    send(32'd99999999, 1'b1, -1);
    send(32'd100000000, 1'b1, 30);
    send(32'h00000A00, 1'b0, -1);

    // Reset during the conversion
    @(negedge clk);
    bus.value = 32'd12345678;
    bus.mode  = 1'b1;
    bus.load  = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    model_zero();
    #1;
    check("busy_rst", 32'(bus.busy), 32'd0);
    check("an_rst_async", 32'(an_n), 32'hFF);
    check("seg_rst_async", 32'(seg_n), 32'hFF);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (40) @(posedge clk);

    for (int n = 0; n < 24; n++) begin
      dec = 1'($urandom);
      case ($urandom % 3)
        0:       v = $urandom;
        1:       v = $urandom % 100000000;
        default: v = $urandom % 1000;
      endcase
      inj = ($urandom % 4 == 0) ? int'($urandom_range(1, 30)) : -1;
      send(v, dec, inj);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
